// File: rtl/vram_arbiter.sv
// vram_arbiter: shares one single-port frame-buffer RAM between VGA scan-out,
// a valid/ready pixel writer and a built-in clear engine. Display reads win.
//
// Ports:
//   clk, reset               pixel clock, synchronous active-high reset
//   x, y, video_on           scan position / display-active from vga_sync
//   hsync_in, vsync_in       syncs from vga_sync
//   wr_valid/wr_ready        writer handshake; wr_addr linear, wr_data pixel
//   clear_start/clear_color  one-cycle pulse to fill the fb with a color
//   clear_busy               clear in progress
//   wr_err                   sticky: out-of-range write accepted and dropped
//   mem_en/we/addr/wdata     RAM command, mem_rdata 1 cycle read latency
//   pix_data                 pixel to DAC, 0 outside display
//   hsync_out, vsync_out     syncs delayed 2 cycles to match pix_data
module vram_arbiter #(
    parameter int DATA_W         = 12,
    parameter int ADDR_W         = 15,
    parameter int FB_WIDTH       = 160,
    parameter int FB_HEIGHT      = 120,
    parameter int SCALE_SHIFT    = 2,
    parameter int V_DISPLAY      = 480,
    parameter int WR_VBLANK_ONLY = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        x,
    input  logic [9:0]        y,
    input  logic              video_on,
    input  logic              hsync_in,
    input  logic              vsync_in,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clear_start,
    input  logic [DATA_W-1:0] clear_color,
    output logic              clear_busy,
    output logic              wr_err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              hsync_out,
    output logic              vsync_out
);

    localparam int FB_SIZE = FB_WIDTH * FB_HEIGHT;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_SIZE - 1);

    typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

    state_t            state, state_nx;
    logic              pend_v, pend_v_nx;
    logic [ADDR_W-1:0] pend_addr;
    logic [DATA_W-1:0] pend_data;
    logic              clear_req, clear_req_nx;
    logic [DATA_W-1:0] clr_color;
    logic [ADDR_W-1:0] clr_cnt, clr_cnt_nx;
    logic              disp_rd, vblank_ok, free;
    logic              in_range, accept, wr_fire;
    logic              pend_issue, clr_issue;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_d1, von_d1, von_d2;
    logic [DATA_W-1:0] pix_q;
    logic [1:0]        hs_d, vs_d;

    assign disp_rd = video_on && (x[SCALE_SHIFT-1:0] == '0);
    assign rd_addr = ADDR_W'(y >> SCALE_SHIFT) * ADDR_W'(FB_WIDTH)
                   + ADDR_W'(x >> SCALE_SHIFT);

    assign vblank_ok = (WR_VBLANK_ONLY == 0) || (y >= 10'(V_DISPLAY));
    assign free      = !disp_rd && vblank_ok;

    // Accept when empty, or when the held write drains this very cycle.
    assign wr_ready = (state == IDLE) && !clear_req && (!pend_v || free);
    assign in_range = (wr_addr <= LAST);
    assign accept   = wr_valid && wr_ready;
    assign wr_fire  = accept && in_range;

    always_comb begin
        state_nx     = state;
        clear_req_nx = clear_req;
        clr_cnt_nx   = clr_cnt;
        pend_issue   = 1'b0;
        clr_issue    = 1'b0;
        mem_en       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;

        if (disp_rd) begin
            mem_en   = 1'b1;
            mem_addr = rd_addr;
        end else if (free) begin
            if (state == CLEAR) begin
                clr_issue = 1'b1;
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = clr_cnt;
                mem_wdata = clr_color;
            end else if (pend_v) begin
                pend_issue = 1'b1;
                mem_en     = 1'b1;
                mem_we     = 1'b1;
                mem_addr   = pend_addr;
                mem_wdata  = pend_data;
            end
        end

        pend_v_nx = wr_fire || (pend_v && !pend_issue);

        unique case (state)
            IDLE: begin
                if (clear_start) begin
                    clear_req_nx = 1'b1;
                    clr_cnt_nx   = '0;
                    // A write accepted alongside the pulse is flushed first.
                    state_nx = pend_v_nx ? DRAIN : CLEAR;
                end
            end
            DRAIN: begin
                if (pend_issue) state_nx = CLEAR;
            end
            CLEAR: begin
                if (clr_issue) begin
                    if (clr_cnt == LAST) begin
                        state_nx     = IDLE;
                        clear_req_nx = 1'b0;
                    end else begin
                        clr_cnt_nx = clr_cnt + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pend_v    <= 1'b0;
            pend_addr <= '0;
            pend_data <= '0;
            clear_req <= 1'b0;
            clr_color <= '0;
            clr_cnt   <= '0;
            wr_err    <= 1'b0;
            rd_d1     <= 1'b0;
            von_d1    <= 1'b0;
            von_d2    <= 1'b0;
            pix_q     <= '0;
            hs_d      <= '0;
            vs_d      <= '0;
        end else begin
            state     <= state_nx;
            pend_v    <= pend_v_nx;
            clear_req <= clear_req_nx;
            clr_cnt   <= clr_cnt_nx;
            if (wr_fire) begin
                pend_addr <= wr_addr;
                pend_data <= wr_data;
            end
            if (state == IDLE && clear_start) clr_color <= clear_color;
            if (accept && !in_range) wr_err <= 1'b1;
            rd_d1  <= disp_rd;
            if (rd_d1) pix_q <= mem_rdata;
            von_d1 <= video_on;
            von_d2 <= von_d1;
            hs_d   <= {hs_d[0], hsync_in};
            vs_d   <= {vs_d[0], vsync_in};
        end
    end

    assign clear_busy = (state != IDLE);
    assign pix_data   = von_d2 ? pix_q : '0;
    assign hsync_out  = hs_d[1];
    assign vsync_out  = vs_d[1];

endmodule
